// File: rtl/cpu_out_buffer.sv
// Capture FIFO for the CPU output port: stores every out_signal word, drains via valid/ready.
// Tracks CPU halt and raises done once halted and every captured word has been read.
module cpu_out_buffer #(
  parameter int DEPTH = 16,
  parameter int WIDTH = 64
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     out_signal,
  input  logic [WIDTH-1:0]         out_data,
  input  logic                     halt,
  input  logic                     rd_ready,
  output logic                     rd_valid,
  output logic [WIDTH-1:0]         rd_data,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     full,
  output logic                     empty,
  output logic                     overflow,
  input  logic                     clr_overflow,
  output logic                     done
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0]   CNT_FULL = (AW+1)'(DEPTH);
  localparam logic [AW:0]   CNT_ONE  = (AW+1)'(1);
  localparam logic [AW-1:0] PTR_ONE  = AW'(1);

  typedef enum logic [1:0] {ST_RUN, ST_DRAIN, ST_DONE} state_t;

  state_t           r_state;
  state_t           w_state_nxt;
  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wp;
  logic [AW-1:0]    r_rp;
  logic [AW:0]      r_count;
  logic [AW:0]      w_count_nxt;
  logic             r_overflow;
  logic             w_push;
  logic             w_pop;
  logic             w_push_acc;
  logic             w_drop;

  assign count    = r_count;
  assign full     = (r_count == CNT_FULL);
  assign empty    = (r_count == '0);
  assign rd_valid = !empty;
  assign rd_data  = empty ? '0 : r_mem[r_rp];
  assign overflow = r_overflow;
  assign done     = (r_state == ST_DONE);

  assign w_push     = out_signal && (r_state == ST_RUN);
  assign w_pop      = rd_valid && rd_ready;
  // A pop in the same cycle frees the slot, so a full FIFO still takes the push.
  assign w_push_acc = w_push && (!full || w_pop);
  assign w_drop     = w_push && full && !w_pop;

  always_comb begin
    w_count_nxt = r_count;
    if (w_push_acc && !w_pop)
      w_count_nxt = r_count + CNT_ONE;
    else if (!w_push_acc && w_pop)
      w_count_nxt = r_count - CNT_ONE;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_RUN: begin
        if (halt)
          w_state_nxt = (w_count_nxt == '0) ? ST_DONE : ST_DRAIN;
      end
      ST_DRAIN: begin
        if (w_count_nxt == '0)
          w_state_nxt = ST_DONE;
      end
      ST_DONE:  w_state_nxt = ST_DONE;
      default:  w_state_nxt = ST_RUN;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state    <= ST_RUN;
      r_wp       <= '0;
      r_rp       <= '0;
      r_count    <= '0;
      r_overflow <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_count <= w_count_nxt;
      if (w_push_acc)
        r_wp <= r_wp + PTR_ONE;
      if (w_pop)
        r_rp <= r_rp + PTR_ONE;
      // A fresh drop outranks a simultaneous clear.
      if (w_drop)
        r_overflow <= 1'b1;
      else if (clr_overflow)
        r_overflow <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (w_push_acc)
      r_mem[r_wp] <= out_data;
  end

endmodule
